sobel_line_buffer: RTL and testbench

//  Upstream stage of the Sobel window assembler. Accepts a raster pixel stream of one row-major frame.

---
 rtl/sobel_pkg.sv | 15 +
 rtl/sobel_line_ram.sv | 35 +++
 rtl/sobel_line_buffer.sv | 141 ++++++++++++++
 tb/tb_sobel_line_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and FSM encoding for the Sobel window pipeline.
// The ROWS/COLS defaults are also used by the downstream window assembler.
package sobel_pkg;

  localparam int unsigned SOBEL_DW   = 8;
  localparam int unsigned SOBEL_COLS = 113;
  localparam int unsigned SOBEL_ROWS = 170;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sobel_line_ram.sv
// One line memory: DEPTH x DW simple dual-port RAM, synchronous read-first.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, data appears on o_rdata after the edge
//   o_rdata  registered read data (pre-write contents on address collision)
module sobel_line_ram
  import sobel_pkg::*;
#(
  parameter int unsigned DW    = SOBEL_DW,
  parameter int unsigned DEPTH = SOBEL_COLS,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Storage has no reset; contents survive rst.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_line_buffer.sv
// Sobel line buffer: turns a raster pixel stream into vertically aligned
// column triplets (top/centre/bottom), with a flush phase for the last row.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pixel_i/valid_i input stream, transfer when valid_i & ready_o
//   ready_o         high in FILL/RUN, low in FLUSH and after reset edges
//   d0_o/d1_o/d2_o  bottom (r+1) / centre (r) / top (r-1) pixels
//   done_o          one-cycle strobe per new triplet
//   frame_done_o    strobe coincident with the last triplet of a frame
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DW   = SOBEL_DW,
  parameter int unsigned COLS = SOBEL_COLS,
  parameter int unsigned ROWS = SOBEL_ROWS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pixel_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] d0_o,
  output logic [DW-1:0] d1_o,
  output logic [DW-1:0] d2_o,
  output logic          done_o,
  output logic          frame_done_o
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [RW-1:0] r_row;
  logic          r_sel;
  logic          r_ready, r_done, r_frame_done;
  logic [DW-1:0] r_d0, r_d1, r_d2;

  logic          w_xfer, w_flush, w_step, w_col_wrap;
  logic          w_ready_nxt, w_done_nxt, w_frame_done_nxt, w_mask_top;
  logic          w_we_a, w_we_b;
  logic [DW-1:0] w_q_a, w_q_b, w_q_old, w_q_cur;

  assign w_xfer     = valid_i & r_ready;
  assign w_flush    = (r_state == ST_FLUSH);
  assign w_step     = w_xfer | w_flush;
  assign w_col_wrap = (r_col == COL_LAST);
  assign w_col_nxt  = !w_step ? r_col : (w_col_wrap ? '0 : r_col + CW'(1));

  // r_sel = 0: RAM A holds row r-1 (and takes the incoming row), RAM B row r.
  assign w_q_old = r_sel ? w_q_b : w_q_a;
  assign w_q_cur = r_sel ? w_q_a : w_q_b;

  // Both RAMs are read at the column about to be processed, so their
  // registered outputs are ready on the accepting edge and the output
  // registers can capture them directly (one-cycle latency overall).
  sobel_line_ram #(.DW(DW), .DEPTH(COLS)) u_ram_a (
    .i_clk  (clk),
    .i_we   (w_we_a),
    .i_waddr(r_col),
    .i_wdata(pixel_i),
    .i_raddr(w_col_nxt),
    .o_rdata(w_q_a)
  );

  sobel_line_ram #(.DW(DW), .DEPTH(COLS)) u_ram_b (
    .i_clk  (clk),
    .i_we   (w_we_b),
    .i_waddr(r_col),
    .i_wdata(pixel_i),
    .i_raddr(w_col_nxt),
    .o_rdata(w_q_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL:  if (w_xfer && w_col_wrap) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_xfer && w_col_wrap && (r_row == ROW_LAST)) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_col_wrap) w_state_nxt = ST_FILL;
      default:  w_state_nxt = ST_FILL;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    w_ready_nxt      = (w_state_nxt != ST_FLUSH);
    w_done_nxt       = ((r_state == ST_RUN) && w_xfer) || w_flush;
    w_frame_done_nxt = w_flush && w_col_wrap;
    w_mask_top       = (r_state == ST_RUN) && (r_row == RW'(1));
    w_we_a           = w_xfer & ~r_sel;
    w_we_b           = w_xfer &  r_sel;
  end

  // Counters, ping-pong select and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_sel        <= 1'b0;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_frame_done <= 1'b0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_d2         <= '0;
    end else begin
      r_col        <= w_col_nxt;
      r_ready      <= w_ready_nxt;
      r_done       <= w_done_nxt;
      r_frame_done <= w_frame_done_nxt;
      // Rows only advance on real transfers; flush steps leave row at 0.
      if (w_xfer && w_col_wrap) begin
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        r_sel <= ~r_sel;
      end
      if (w_done_nxt) begin
        r_d0 <= w_flush ? '0 : pixel_i;
        r_d1 <= w_q_cur;
        r_d2 <= w_mask_top ? '0 : w_q_old;
      end
    end
  end

  assign ready_o      = r_ready;
  assign done_o       = r_done;
  assign frame_done_o = r_frame_done;
  assign d0_o         = r_d0;
  assign d1_o         = r_d1;
  assign d2_o         = r_d2;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench: a small 4x3 instance for directed scenarios and a
// default-size instance for randomized multi-frame streams.
module tb_sobel_line_buffer;

  localparam int SC = 4;
  localparam int SR = 3;
  localparam int BC = 113;
  localparam int BR = 170;

  typedef struct packed {
    logic [7:0] d2;
    logic [7:0] d1;
    logic [7:0] d0;
    logic       fd;
  } trip_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_pix, s_d0, s_d1, s_d2;
  logic       s_valid, s_ready, s_done, s_fd;
  logic [7:0] b_pix, b_d0, b_d1, b_d2;
  logic       b_valid, b_ready, b_done, b_fd;

  sobel_line_buffer #(.DW(8), .COLS(SC), .ROWS(SR)) u_small (
    .clk(clk), .rst(rst), .pixel_i(s_pix), .valid_i(s_valid), .ready_o(s_ready),
    .d0_o(s_d0), .d1_o(s_d1), .d2_o(s_d2), .done_o(s_done), .frame_done_o(s_fd)
  );

  sobel_line_buffer u_big (
    .clk(clk), .rst(rst), .pixel_i(b_pix), .valid_i(b_valid), .ready_o(b_ready),
    .d0_o(b_d0), .d1_o(b_d1), .d2_o(b_d2), .done_o(b_done), .frame_done_o(b_fd)
  );

  trip_t      q_s[$], q_b[$];
  int         n_cmp = 0, n_err = 0;
  int         cyc = 0;
  logic [7:0] fr [0:BR*BC-1];
  int         s_acc[$], s_dn[$], s_fdq[$];
  bit         rdy_log [0:8191];
  int         b_done_cnt = 0, b_fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  // Small-instance transfers, stamped with the edge number that accepts them.
  always @(posedge clk) if (!rst && s_valid && s_ready) s_acc.push_back(cyc + 1);

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_trip(input string name, input trip_t got, input trip_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got d2/d1/d0/fd=%0d/%0d/%0d/%0b, expected %0d/%0d/%0d/%0b (cycle %0d)",
               name, got.d2, got.d1, got.d0, got.fd, exp.d2, exp.d1, exp.d0, exp.fd, cyc);
    end
  endtask

  // Reference: window for centre row cr, column c, straight from the frame.
  task automatic exp_frame(input bit big, input int rows, input int cols, input int limit);
    int k = 0;
    trip_t t;
    for (int cr = 0; cr < rows; cr++) begin
      for (int c = 0; c < cols; c++) begin
        t.d1 = fr[cr*cols + c];
        if (cr == 0) t.d2 = 8'd0; else t.d2 = fr[(cr-1)*cols + c];
        if (cr == rows-1) t.d0 = 8'd0; else t.d0 = fr[(cr+1)*cols + c];
        t.fd = (cr == rows-1) && (c == cols-1);
        if (k < limit) begin
          if (big) q_b.push_back(t); else q_s.push_back(t);
        end
        k++;
      end
    end
  endtask

  task automatic fill_pattern(input int off);
    for (int r = 0; r < SR; r++)
      for (int c = 0; c < SC; c++)
        fr[r*SC + c] = 8'(4*r + c + 1 + off);
  endtask

  // hold=1 keeps valid high with junk data while ready is low.
  task automatic drive_s(input int n, input bit rnd, input bit hold);
    int i = 0, g = 0;
    while (i < n && g < 4*n + 1000) begin
      @(negedge clk);
      g++;
      if (!s_ready && hold) begin
        s_valid = 1'b1;
        s_pix   = 8'($urandom);
      end else begin
        s_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_pix   = fr[i];
        if (s_valid && s_ready) i++;
      end
    end
    if (i < n) begin
      n_cmp++; n_err++;
      $display("FAIL s_drive_timeout: sent %0d, required %0d", i, n);
    end
  endtask

  task automatic drive_b(input int n, input bit rnd, input bit hold);
    int i = 0, g = 0;
    while (i < n && g < 4*n + 1000) begin
      @(negedge clk);
      g++;
      if (!b_ready && hold) begin
        b_valid = 1'b1;
        b_pix   = 8'($urandom);
      end else begin
        b_valid = rnd ? ($urandom_range(0, 15) != 0) : 1'b1;
        b_pix   = fr[i];
        if (b_valid && b_ready) i++;
      end
    end
    if (i < n) begin
      n_cmp++; n_err++;
      $display("FAIL b_drive_timeout: sent %0d, required %0d", i, n);
    end
  endtask

  task automatic wait_idle_s();
    int g = 0;
    do begin
      @(negedge clk);
      s_valid = 1'b0;
      g++;
    end while (!(s_ready && q_s.size() == 0) && g < 500);
    if (g >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL s_idle_timeout: pending %0d, required 0", q_s.size());
    end
  endtask

  task automatic wait_idle_b();
    int g = 0;
    do begin
      @(negedge clk);
      b_valid = 1'b0;
      g++;
    end while (!(b_ready && q_b.size() == 0) && g < 2000);
    if (g >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL b_idle_timeout: pending %0d, required 0", q_b.size());
    end
  endtask

  // Small-instance monitor: scoreboard pop on done, hold check otherwise.
  initial begin
    trip_t got, exp, last;
    last = '0;
    forever begin
      @(negedge clk);
      if (cyc < 8192) rdy_log[cyc] = s_ready;
      got = {s_d2, s_d1, s_d0, s_fd};
      if (rst) begin
        last = '0;
      end else if (s_done) begin
        s_dn.push_back(cyc);
        if (s_fd) s_fdq.push_back(cyc);
        if (q_s.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL s_extra_triplet: got %0d/%0d/%0d, expected no triplet", s_d2, s_d1, s_d0);
        end else begin
          exp = q_s.pop_front();
          check_trip("s_triplet", got, exp);
        end
        last = got;
        last.fd = 1'b0;
      end else begin
        check_trip("s_hold", got, last);
      end
    end
  end

  // Default-size monitor.
  initial begin
    trip_t got, exp;
    forever begin
      @(negedge clk);
      if (!rst && b_done) begin
        got = {b_d2, b_d1, b_d0, b_fd};
        b_done_cnt++;
        if (b_fd) b_fd_cnt++;
        if (q_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_extra_triplet: got %0d/%0d/%0d, expected no triplet", b_d2, b_d1, b_d0);
        end else begin
          exp = q_b.pop_front();
          check_trip("b_triplet", got, exp);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0; s_pix = '0;
    b_valid = 1'b0; b_pix = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", s_ready, 0);
    check("rst_done", s_done, 0);
    check("rst_frame_done", s_fd, 0);
    check("rst_data", {s_d2, s_d1, s_d0}, 0);
    check("rst_big_ready", b_ready, 0);
    rst = 1'b0;

    // Continuous frame, then flush timing.
    s_acc.delete(); s_dn.delete(); s_fdq.delete();
    fill_pattern(0);
    exp_frame(1'b0, SR, SC, SR*SC);
    drive_s(SR*SC, 1'b0, 1'b0);
    wait_idle_s();
    check("s1_xfers", s_acc.size(), 12);
    check("s1_dones", s_dn.size(), 12);
    check("s1_frame_dones", s_fdq.size(), 1);
    if (s_acc.size() == 12 && s_dn.size() == 12 && s_fdq.size() == 1) begin
      for (int i = 0; i < 8; i++) check("s1_latency", s_dn[i] - s_acc[i+4], 0);
      for (int j = 0; j < 4; j++) check("s2_flush_cycle", s_dn[8+j] - s_acc[11], 1 + j);
      for (int k = 0; k < 4; k++) check("s2_ready_low", int'(rdy_log[s_acc[11]+k]), 0);
      check("s2_ready_back", int'(rdy_log[s_acc[11]+4]), 1);
      check("s2_fd_last", s_fdq[0], s_dn[11]);
    end

    // Random valid gaps with valid held during flush, then +100 frame back-to-back.
    s_acc.delete(); s_dn.delete(); s_fdq.delete();
    fill_pattern(0);
    exp_frame(1'b0, SR, SC, SR*SC);
    drive_s(SR*SC, 1'b1, 1'b1);
    fill_pattern(100);
    exp_frame(1'b0, SR, SC, SR*SC);
    drive_s(SR*SC, 1'b0, 1'b1);
    wait_idle_s();
    check("s3_xfers", s_acc.size(), 24);
    check("s3_frame_dones", s_fdq.size(), 2);
    check("s3_dones", s_dn.size(), 24);
    if (s_acc.size() >= 13 && s_fdq.size() >= 1)
      check("s4_back_to_back", s_acc[12], s_fdq[0] + 1);

    // Reset mid-frame at (row1, col2).
    fill_pattern(0);
    exp_frame(1'b0, SR, SC, 2);
    drive_s(6, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b1; s_pix = fr[6];
    @(negedge clk);
    check("s5_done_after_rst", s_done, 0);
    check("s5_ready_in_rst", s_ready, 0);
    check("s5_data_after_rst", {s_d2, s_d1, s_d0}, 0);
    check("s5_pending", q_s.size(), 0);
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("s5_ready_after_release", s_ready, 1);
    exp_frame(1'b0, SR, SC, SR*SC);
    drive_s(SR*SC, 1'b0, 1'b0);
    wait_idle_s();

    // Default geometry, three random frames back-to-back.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < BR*BC; i++) fr[i] = 8'($urandom);
      exp_frame(1'b1, BR, BC, BR*BC);
      drive_b(BR*BC, 1'b1, 1'b1);
    end
    wait_idle_b();
    check("b_done_count", b_done_cnt, 3*BR*BC);
    check("b_frame_done_count", b_fd_cnt, 3);
    check("s_queue_empty", q_s.size(), 0);
    check("b_queue_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
